// File: rtl/comma_inserter.sv
// Line-side alignment/idle/repeat-substitution inserter: bursts alignment words on link start,
// then forwards payload words with periodic alignment, idle fill and per-lane repeat substitution.
module comma_inserter #(
  parameter int unsigned LANES    = 2,
  parameter int unsigned PERIOD   = 256,
  parameter int unsigned BURST    = 4,
  parameter logic [7:0]  K_ALIGN  = 8'hBC,
  parameter logic [7:0]  K_IDLE   = 8'h7C,
  parameter logic [7:0]  K_REPEAT = 8'hFC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 rep_en,
  input  logic [8*LANES-1:0]   in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [8*LANES-1:0]   tx_data,
  output logic [LANES-1:0]     tx_k,
  output logic                 running,
  output logic [15:0]          subst_cnt
);

  localparam int unsigned DW = 8 * LANES;
  localparam int unsigned PW = $clog2(PERIOD);
  localparam int unsigned BW = $clog2(BURST + 1);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {S_OFF, S_BURST, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     pcnt_q, pcnt_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [DW-1:0]     tx_data_d;
  logic [LANES-1:0]  tx_k_d;
  logic [DW-1:0]     hist_q, hist_d;
  logic [LANES-1:0]  hist_v_q, hist_v_d;
  logic [LANES-1:0]  subst_mask;
  logic [CW-1:0]     subst_num;
  logic [16:0]       subst_sum;
  logic [15:0]       subst_cnt_d;
  logic              pcnt_last;

  assign pcnt_last = (pcnt_q == PW'(PERIOD - 1));

  // Next-state, line word and repeat history
  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    bcnt_d     = bcnt_q;
    tx_data_d  = '0;
    tx_k_d     = '0;
    hist_d     = hist_q;
    hist_v_d   = hist_v_q;
    subst_mask = '0;
    in_ready   = 1'b0;

    if (!en) begin
      state_d = S_OFF;
      pcnt_d  = '0;
      bcnt_d  = '0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = S_BURST;
          bcnt_d  = '0;
        end
        S_BURST: begin
          tx_data_d = {LANES{K_ALIGN}};
          tx_k_d    = '1;
          if (bcnt_q == BW'(BURST - 1)) begin
            state_d  = S_RUN;
            pcnt_d   = '0;
            bcnt_d   = '0;
            hist_v_d = '0;
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
        S_RUN: begin
          pcnt_d = pcnt_last ? '0 : pcnt_q + PW'(1);
          if (pcnt_last) begin
            tx_data_d = {LANES{K_ALIGN}};
            tx_k_d    = '1;
            hist_v_d  = '0;
          end else begin
            in_ready = 1'b1;
            if (in_valid) begin
              for (int i = 0; i < int'(LANES); i++) begin
                if (rep_en && hist_v_q[i] && (in_data[8*i +: 8] == hist_q[8*i +: 8])) begin
                  tx_data_d[8*i +: 8] = K_REPEAT;
                  tx_k_d[i]           = 1'b1;
                  subst_mask[i]       = 1'b1;
                end else begin
                  tx_data_d[8*i +: 8] = in_data[8*i +: 8];
                  hist_d[8*i +: 8]    = in_data[8*i +: 8];
                  hist_v_d[i]         = 1'b1;
                end
              end
            end else begin
              tx_data_d = {LANES{K_IDLE}};
              tx_k_d    = '1;
            end
          end
        end
        default: state_d = S_OFF;
      endcase
    end
  end

  // Saturating substitution counter, all lanes of a word added at once
  always_comb begin
    subst_num = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      subst_num = subst_num + CW'(subst_mask[i]);
    end
    subst_sum   = 17'(subst_cnt) + 17'(subst_num);
    subst_cnt_d = subst_sum[16] ? 16'hFFFF : subst_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_OFF;
      pcnt_q    <= '0;
      bcnt_q    <= '0;
      hist_q    <= '0;
      hist_v_q  <= '0;
      tx_data   <= '0;
      tx_k      <= '0;
      running   <= 1'b0;
      subst_cnt <= '0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      bcnt_q    <= bcnt_d;
      hist_q    <= hist_d;
      hist_v_q  <= hist_v_d;
      tx_data   <= tx_data_d;
      tx_k      <= tx_k_d;
      running   <= (state_d == S_RUN);
      subst_cnt <= subst_cnt_d;
    end
  end

endmodule

// File: tb/tb_comma_inserter.sv
// Directed bench for comma_inserter: vector table for the main flow, hand sequences for
// asynchronous reset and counter saturation (second, wide instance).
module tb_comma_inserter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, rep_en, in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [15:0] tx_data;
  logic [1:0]  tx_k;
  logic        running;
  logic [15:0] subst_cnt;

  logic        en2, rep2, valid2;
  logic [63:0] data2;
  logic        ready2;
  logic [63:0] tx2;
  logic [7:0]  k2;
  logic        run2;
  logic [15:0] cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  comma_inserter #(.LANES(2), .PERIOD(8), .BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rep_en(rep_en),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .tx_data(tx_data), .tx_k(tx_k), .running(running), .subst_cnt(subst_cnt)
  );

  comma_inserter #(.LANES(8), .PERIOD(65536), .BURST(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en2), .rep_en(rep2),
    .in_data(data2), .in_valid(valid2), .in_ready(ready2),
    .tx_data(tx2), .tx_k(k2), .running(run2), .subst_cnt(cnt2)
  );

  typedef struct {
    logic        en;
    logic        rep;
    logic        valid;
    logic [15:0] data;
    logic        rdy;
    logic [15:0] tx;
    logic [1:0]  k;
    logic        run;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic e, logic r, logic v, logic [15:0] d, logic rd,
                              logic [15:0] t, logic [1:0] kk, logic rn, logic [15:0] c);
    vec_t x;
    x.en = e; x.rep = r; x.valid = v; x.data = d; x.rdy = rd;
    x.tx = t; x.k = kk; x.run = rn; x.cnt = c;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; rep_en = 1'b0; in_valid = 1'b0; in_data = '0;
    en2 = 1'b0; rep2 = 1'b0; valid2 = 1'b0; data2 = '0;

    //          en rep val data      rdy tx        k      run cnt
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 2'b00, 0, 16'd0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 2'b00, 0, 16'd0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'hBCBC, 2'b11, 0, 16'd0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'hBCBC, 2'b11, 0, 16'd0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'hBCBC, 2'b11, 0, 16'd0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'hBCBC, 2'b11, 1, 16'd0));
    vecs.push_back(mk(1, 0, 1, 16'h1111, 1, 16'h1111, 2'b00, 1, 16'd0));
    vecs.push_back(mk(1, 0, 1, 16'h1111, 1, 16'h1111, 2'b00, 1, 16'd0));
    vecs.push_back(mk(1, 0, 1, 16'h2233, 1, 16'h2233, 2'b00, 1, 16'd0));
    vecs.push_back(mk(1, 0, 1, 16'h4455, 1, 16'h4455, 2'b00, 1, 16'd0));
    vecs.push_back(mk(1, 0, 1, 16'h6677, 1, 16'h6677, 2'b00, 1, 16'd0));
    vecs.push_back(mk(1, 0, 1, 16'h8899, 1, 16'h8899, 2'b00, 1, 16'd0));
    vecs.push_back(mk(1, 0, 1, 16'hAABB, 1, 16'hAABB, 2'b00, 1, 16'd0));
    vecs.push_back(mk(1, 0, 1, 16'hCCDD, 0, 16'hBCBC, 2'b11, 1, 16'd0));
    vecs.push_back(mk(1, 1, 1, 16'h1234, 1, 16'h1234, 2'b00, 1, 16'd0));
    vecs.push_back(mk(1, 1, 1, 16'h1234, 1, 16'hFCFC, 2'b11, 1, 16'd2));
    vecs.push_back(mk(1, 1, 1, 16'h1255, 1, 16'hFC55, 2'b10, 1, 16'd3));
    vecs.push_back(mk(1, 1, 0, 16'h1255, 1, 16'h7C7C, 2'b11, 1, 16'd3));
    vecs.push_back(mk(1, 1, 1, 16'h1255, 1, 16'hFCFC, 2'b11, 1, 16'd5));
    vecs.push_back(mk(1, 0, 1, 16'h1255, 1, 16'h1255, 2'b00, 1, 16'd5));
    vecs.push_back(mk(1, 1, 1, 16'h1255, 1, 16'hFCFC, 2'b11, 1, 16'd7));
    vecs.push_back(mk(1, 1, 1, 16'h1255, 0, 16'hBCBC, 2'b11, 1, 16'd7));
    vecs.push_back(mk(1, 1, 1, 16'h1255, 1, 16'h1255, 2'b00, 1, 16'd7));
    vecs.push_back(mk(1, 1, 1, 16'h55AA, 1, 16'h55AA, 2'b00, 1, 16'd7));
    vecs.push_back(mk(0, 1, 1, 16'h55AA, 0, 16'h0000, 2'b00, 0, 16'd7));
    vecs.push_back(mk(0, 1, 1, 16'h55AA, 0, 16'h0000, 2'b00, 0, 16'd7));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 16'h0000, 2'b00, 0, 16'd7));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 16'hBCBC, 2'b11, 0, 16'd7));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 16'hBCBC, 2'b11, 0, 16'd7));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 16'hBCBC, 2'b11, 0, 16'd7));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 16'hBCBC, 2'b11, 1, 16'd7));
    vecs.push_back(mk(1, 1, 1, 16'h1255, 1, 16'h1255, 2'b00, 1, 16'd7));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", 64'(tx_data), 64'h0);
    chk("rst_k", 64'(tx_k), 64'h0);
    chk("rst_running", 64'(running), 64'h0);
    chk("rst_cnt", 64'(subst_cnt), 64'h0);
    chk("rst_ready", 64'(in_ready), 64'h0);

    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[n]) begin
      @(negedge clk);
      en = vecs[n].en; rep_en = vecs[n].rep; in_valid = vecs[n].valid; in_data = vecs[n].data;
      #1;
      chk($sformatf("v%0d_ready", n), 64'(in_ready), 64'(vecs[n].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_tx", n), 64'(tx_data), 64'(vecs[n].tx));
      chk($sformatf("v%0d_k", n), 64'(tx_k), 64'(vecs[n].k));
      chk($sformatf("v%0d_running", n), 64'(running), 64'(vecs[n].run));
      chk($sformatf("v%0d_cnt", n), 64'(subst_cnt), 64'(vecs[n].cnt));
    end

    // Asynchronous reset pulse mid-RUN, away from any clock edge
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_tx", 64'(tx_data), 64'h0);
    chk("arst_k", 64'(tx_k), 64'h0);
    chk("arst_running", 64'(running), 64'h0);
    chk("arst_cnt", 64'(subst_cnt), 64'h0);
    chk("arst_ready", 64'(in_ready), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_tx", 64'(tx_data), 64'h0);
    chk("rel_running", 64'(running), 64'h0);
    @(posedge clk);
    #1;
    chk("rel_burst_tx", 64'(tx_data), 64'hBCBC);
    chk("rel_burst_k", 64'(tx_k), 64'h3);

    // Saturation on the wide instance: 8 lanes substituted per word after the first
    @(negedge clk);
    en = 1'b0;
    en2 = 1'b1; rep2 = 1'b1; valid2 = 1'b1; data2 = 64'h0123456789ABCDEF;
    repeat (2) @(posedge clk);
    #1;
    chk("sat_running", 64'(run2), 64'h1);
    for (int n = 1; n <= 8194; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        chk("sat_first_tx", tx2, 64'h0123456789ABCDEF);
        chk("sat_first_k", 64'(k2), 64'h00);
      end
      if (n == 2) begin
        chk("sat_rep_tx", tx2, 64'hFCFCFCFCFCFCFCFC);
        chk("sat_rep_k", 64'(k2), 64'hFF);
        chk("sat_cnt_8", 64'(cnt2), 64'd8);
      end
      if (n == 8192) chk("sat_cnt_fff8", 64'(cnt2), 64'hFFF8);
      if (n == 8193) chk("sat_cnt_ffff", 64'(cnt2), 64'hFFFF);
      if (n == 8194) chk("sat_cnt_hold", 64'(cnt2), 64'hFFFF);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
